selector_decode: RTL and testbench
==================================

// Module: selector_decode
// PURPOSE
//  Inverse of the registered code selector: accepts a stream of 7-bit arithmetic codes
//  (code = BASE + STEP*sel) and recovers the selection index. Codes outside the valid set
//  are flagged and counted.
//  Sits on the receive side of the selector code path, between the code source and the
//  index consumer. Uses valid/ready on both sides through a 2-stage pipeline.
// PARAMETERS
//  CODE_W  7   code width
//  SEL_W   4   recovered index width; the valid set has 2**SEL_W codes
//  BASE    10  code for index 0
//  STEP    3   code increment per index; must be >0
//  CNT_W   8   error counter width
//  Legal only when BASE + STEP*(2**SEL_W-1) < 2**CODE_W (defaults: max code 55 < 128).
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       synchronous reset, active-high
//  in_valid   in   1       in_code is valid
//  in_ready   out  1       block accepts in_code this cycle
//  in_code    in   CODE_W  code to decode
//  out_valid  out  1       out_sel/out_err are valid
//  out_ready  in   1       consumer accepts the output this cycle
//  out_sel    out  SEL_W   recovered index
//  out_err    out  1       in_code was not a member of the valid set
//  err_clr    in   1       synchronous clear of err_cnt
//  err_cnt    out  CNT_W   saturating count of errored words delivered (only with SELDEC_ERRCNT_EN)
// BEHAVIOUR
//  - Reset: s1_valid=0, out_valid=0, out_sel=0, out_err=0, err_cnt=0. After reset, in_ready=1.
//    Reset applied mid-stream discards all buffered words.
//  - Stage 1 (S1) registers in_code and its valid bit.
//    Stage 2 is the output register; it holds out_sel/out_err and drives out_valid.
//  - Advance conditions:
//      s2_take  = !out_valid | out_ready
//      s1_take  = !s1_valid | s2_take
//      in_ready = s1_take (combinational from out_ready; no combinational in_valid->out path)
//  - Input handshake is in_valid & in_ready. Output handshake is out_valid & out_ready.
//  - Latency: 2 cycles from input handshake to out_valid when out_ready stays high.
//    Throughput: 1 word/cycle. Up to 2 words are buffered under backpressure.
//  - While out_valid=1 and out_ready=0, out_sel/out_err hold stable. No loss, no duplication,
//    order preserved.
//  - Decode is combinational on S1 and registered into stage 2:
//      d = code - BASE, computed in CODE_W+1 bits
//      valid iff code >= BASE, d % STEP == 0, and d/STEP <= 2**SEL_W-1
//      valid:   out_sel = d/STEP, out_err = 0
//      invalid: out_sel = 0,      out_err = 1
//    Implement as a constant compare over the 2**SEL_W table entries. No divider.
//  - Defaults: 10->0, 13->1, ..., 52->14, 55->15. Codes 0..9, 11, 12, 56..127 and
//    non-multiples are errors.
//  - err_cnt increments by 1 on each output handshake with out_err=1, and saturates at
//    2**CNT_W-1.
//  - err_clr has priority: if it is asserted in the same cycle as an errored handshake,
//    err_cnt becomes 0.
// CONFIGURATION
//  SELDEC_ERRCNT_EN defined:
//    err_cnt port present; counter logic as above.
//  SELDEC_ERRCNT_EN undefined:
//    err_cnt port and counter logic absent.
//    err_clr port remains and is ignored.
//    out_err still generated.
//    Datapath timing is identical in both builds.
// TESTING
//  1. Assert rst for 2 cycles -> out_valid=0, out_sel=0, out_err=0, err_cnt=0, in_ready=1.
//  2. out_ready=1; codes 10,13,...,55 back-to-back -> out_sel=0..15 in order, each 2 cycles
//     after its input, out_err=0, no bubbles.
//  3. Codes 11, 9, 56, 127 -> each gives out_err=1, out_sel=0; err_cnt=4 after delivery.
//  4. in_valid=1 with 22,25,28 while out_ready=0 for 5 cycles -> in_ready=0 after 2 accepted;
//     out_sel holds 4. On release, 4,5,6 delivered exactly once, in order.
//  5. Preload err_cnt=255, send code 12 -> err_cnt stays 255.
//     Then err_clr=1 together with an errored handshake -> err_cnt=0.
//  6. rst=1 while 2 words are buffered -> next cycle out_valid=0; discarded words never
//     appear; stream resumes normally after reset.

Source files
------------

// File: rtl/selector_decode.sv
// Recovers the selection index from a BASE + STEP*sel code stream through a 2-stage valid/ready pipeline.
// Define SELDEC_ERRCNT_EN to add the saturating err_cnt_o counter (err_clr_i is ignored otherwise).
module selector_decode #(
  parameter int CODE_W = 7,
  parameter int SEL_W  = 4,
  parameter int BASE   = 10,
  parameter int STEP   = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CODE_W-1:0] in_code_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [SEL_W-1:0]  out_sel_o,
  output logic              out_err_o,
  input  logic              err_clr_i
`ifdef SELDEC_ERRCNT_EN
  ,
  output logic [CNT_W-1:0]  err_cnt_o
`endif
);

  localparam int NSEL = 2 ** SEL_W;

  logic              s1_valid_q, s1_valid_d;
  logic [CODE_W-1:0] s1_code_q, s1_code_d;
  logic              out_valid_q, out_valid_d;
  logic [SEL_W-1:0]  out_sel_q, out_sel_d;
  logic              out_err_q, out_err_d;

  logic              s2_take_s;
  logic              s1_take_s;
  logic              dec_hit_s;
  logic [SEL_W-1:0]  dec_sel_s;

  assign s2_take_s   = !out_valid_q || out_ready_i;
  assign s1_take_s   = !s1_valid_q || s2_take_s;
  assign in_ready_o  = s1_take_s;
  assign out_valid_o = out_valid_q;
  assign out_sel_o   = out_sel_q;
  assign out_err_o   = out_err_q;

  // Table decode: compare the staged code against every legal code, no divider.
  always_comb begin
    dec_hit_s = 1'b0;
    dec_sel_s = {SEL_W{1'b0}};
    for (int i = 0; i < NSEL; i++) begin
      dec_hit_s = dec_hit_s | ({1'b0, s1_code_q} == (CODE_W+1)'(BASE + STEP * i));
      dec_sel_s = ({1'b0, s1_code_q} == (CODE_W+1)'(BASE + STEP * i)) ? SEL_W'(i) : dec_sel_s;
    end
  end

  // Pipeline next-state: stages advance only when their downstream slot frees up.
  always_comb begin
    if (s1_take_s) begin
      s1_valid_d = in_valid_i;
      s1_code_d  = in_valid_i ? in_code_i : s1_code_q;
    end else begin
      s1_valid_d = s1_valid_q;
      s1_code_d  = s1_code_q;
    end

    if (s2_take_s && s1_valid_q) begin
      out_valid_d = 1'b1;
      out_sel_d   = dec_hit_s ? dec_sel_s : {SEL_W{1'b0}};
      out_err_d   = !dec_hit_s;
    end else if (s2_take_s) begin
      out_valid_d = 1'b0;
      out_sel_d   = out_sel_q;
      out_err_d   = out_err_q;
    end else begin
      out_valid_d = out_valid_q;
      out_sel_d   = out_sel_q;
      out_err_d   = out_err_q;
    end
  end

  // Pipeline registers; reset drops any buffered words.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q  <= 1'b0;
      s1_code_q   <= {CODE_W{1'b0}};
      out_valid_q <= 1'b0;
      out_sel_q   <= {SEL_W{1'b0}};
      out_err_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_code_q   <= s1_code_d;
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
      out_err_q   <= out_err_d;
    end
  end

`ifdef SELDEC_ERRCNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  assign err_cnt_o = err_cnt_q;

  // Saturating count of delivered errored words; clear wins over increment.
  always_comb begin
    if (err_clr_i) begin
      err_cnt_d = {CNT_W{1'b0}};
    end else if (out_valid_q && out_ready_i && out_err_q && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Error counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_q <= {CNT_W{1'b0}};
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end
`else
  logic unused_err_clr_s;
  assign unused_err_clr_s = err_clr_i;
`endif

endmodule

// File: tb/tb_selector_decode.sv
// Directed bench for selector_decode: arithmetic reference decode plus an in-order scoreboard.
module tb_selector_decode;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [6:0] in_code = 7'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_sel;
  logic       out_err;
  logic       err_clr = 1'b0;
`ifdef SELDEC_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  selector_decode dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_code_i   (in_code),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_sel_o   (out_sel),
    .out_err_o   (out_err),
    .err_clr_i   (err_clr)
`ifdef SELDEC_ERRCNT_EN
    ,
    .err_cnt_o   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int sel;
    int err;
    int t;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  exp_t e_tmp;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   delivered = 0;
  int   last_sel = -1;
  int   last_err = -1;
  int   mcnt = 0;
  int   prev_sel = 0;
  int   prev_err = 0;
  bit   prev_hold = 1'b0;
  bit   lat_chk = 1'b0;
  int   base_cnt;

  function automatic exp_t model_dec(int code, int t);
    exp_t r;
    int   d;
    d   = code - 10;
    r.t = t;
    if (code >= 10 && (d % 3) == 0 && (d / 3) <= 15) begin
      r.sel = d / 3;
      r.err = 0;
    end else begin
      r.sel = 0;
      r.err = 1;
    end
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every output handshake must match the oldest accepted input.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      prev_hold = 1'b0;
      mcnt = 0;
    end else begin
`ifdef SELDEC_ERRCNT_EN
      chk("err_cnt", int'(err_cnt), mcnt);
`endif
      if (prev_hold) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_sel", int'(out_sel), prev_sel);
        chk("hold_err", int'(out_err), prev_err);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_output", 1, 0);
        end else begin
          e_mon = q.pop_front();
          chk("out_sel", int'(out_sel), e_mon.sel);
          chk("out_err", int'(out_err), e_mon.err);
          if (lat_chk) chk("latency", cyc - e_mon.t, 2);
          delivered++;
          last_sel = int'(out_sel);
          last_err = int'(out_err);
          if (err_clr) mcnt = 0;
          else if (e_mon.err == 1 && mcnt != 255) mcnt++;
        end
      end else if (err_clr) begin
        mcnt = 0;
      end
      prev_hold = out_valid && !out_ready;
      prev_sel  = int'(out_sel);
      prev_err  = int'(out_err);
      if (in_valid && in_ready) q.push_back(model_dec(int'(in_code), cyc));
    end
    cyc++;
  end

  task automatic send(input int code);
    int n = 0;
    in_valid = 1'b1;
    in_code  = 7'(code);
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sel", int'(out_sel), 0);
    chk("rst_out_err", int'(out_err), 0);
    chk("rst_in_ready", int'(in_ready), 1);
`ifdef SELDEC_ERRCNT_EN
    chk("rst_err_cnt", int'(err_cnt), 0);
`endif
    e_tmp = model_dec(52, 0);
    chk("model_52", e_tmp.sel, 14);
    e_tmp = model_dec(55, 0);
    chk("model_55", e_tmp.sel, 15);
    e_tmp = model_dec(11, 0);
    chk("model_11", e_tmp.err, 1);
    e_tmp = model_dec(56, 0);
    chk("model_56", e_tmp.err, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // 2: all legal codes back-to-back, fixed 2-cycle latency
    lat_chk = 1'b1;
    base_cnt = delivered;
    for (int i = 0; i < 16; i++) send(10 + 3 * i);
    drain();
    lat_chk = 1'b0;
    chk("t2_count", delivered - base_cnt, 16);
    chk("t2_last_sel", last_sel, 15);
    chk("t2_last_err", last_err, 0);

    // 3: illegal codes
    base_cnt = delivered;
    send(11);
    send(9);
    send(56);
    send(127);
    drain();
    chk("t3_count", delivered - base_cnt, 4);
    chk("t3_last_err", last_err, 1);
    chk("t3_last_sel", last_sel, 0);
`ifdef SELDEC_ERRCNT_EN
    chk("t3_err_cnt", int'(err_cnt), 4);
`endif

    // 4: backpressure holds two words, then releases in order
    out_ready = 1'b0;
    base_cnt = delivered;
    fork
      begin
        send(22);
        send(25);
        send(28);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        @(negedge clk);
        chk("t4_in_ready", int'(in_ready), 0);
        chk("t4_out_valid", int'(out_valid), 1);
        chk("t4_out_sel", int'(out_sel), 4);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("t4_count", delivered - base_cnt, 3);
    chk("t4_last_sel", last_sel, 6);

    // 5: saturation and clear priority
`ifdef SELDEC_ERRCNT_EN
    for (int i = 0; i < 251; i++) send(12);
    drain();
    chk("t5_sat", int'(err_cnt), 255);
`endif
    send(12);
    drain();
    chk("t5_code12_err", last_err, 1);
`ifdef SELDEC_ERRCNT_EN
    chk("t5_stay_sat", int'(err_cnt), 255);
`endif
    send(11);
    @(posedge clk);
    #1;
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    @(negedge clk);
    chk("t5_clr_last_err", last_err, 1);
`ifdef SELDEC_ERRCNT_EN
    chk("t5_clr_cnt", int'(err_cnt), 0);
`endif
    drain();

    // 6: reset discards buffered words
    out_ready = 1'b0;
    send(22);
    send(25);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_out_valid", int'(out_valid), 0);
    chk("t6_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    base_cnt = delivered;
    repeat (5) @(posedge clk);
    #1;
    chk("t6_discarded", delivered - base_cnt, 0);
    send(40);
    drain();
    chk("t6_resume_count", delivered - base_cnt, 1);
    chk("t6_resume_sel", last_sel, 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
